// File: rtl/comb_shifter.sv
// Registered barrel shifter/rotator: logical, arithmetic, rotate and pass-through
// modes over a log2(LEN)-stage network, with a one-cycle result register.
module comb_shifter #(
  parameter int LEN = 8,
  parameter int WA  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:LEN-1] Ip,
  input  logic [WA-1:0] amt,
  input  logic          dir,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic [0:LEN-1] Op,
  output logic          out_valid
);

  localparam logic [1:0] MODE_LOG  = 2'b00;
  localparam logic [1:0] MODE_ARI  = 2'b01;
  localparam logic [1:0] MODE_ROT  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  // Stages work on [LEN-1:0] copies; Ip index 0 (MSB) lands on bit LEN-1,
  // so "left" is toward the MSB exactly as the numeric << operator.
  logic [LEN-1:0] stg [0:WA];
  logic           fill;

  assign stg[0] = Ip;
  assign fill   = (mode == MODE_ARI) ? Ip[0] : 1'b0;

  for (genvar k = 0; k < WA; k++) begin : g_stage
    localparam int S = 1 << k;
    logic [LEN-1:0] moved;

    always_comb begin
      moved = stg[k];
      case (mode)
        MODE_ROT: begin
          if (dir) moved = {stg[k][S-1:0], stg[k][LEN-1:S]};
          else     moved = {stg[k][LEN-1-S:0], stg[k][LEN-1:LEN-S]};
        end
        MODE_LOG, MODE_ARI: begin
          if (dir) moved = {{S{fill}}, stg[k][LEN-1:S]};
          else     moved = {stg[k][LEN-1-S:0], {S{1'b0}}};
        end
        default: moved = stg[k];
      endcase
    end

    assign stg[k+1] = amt[k] ? moved : stg[k];
  end

  logic [0:LEN-1] res;
  assign res = (mode == MODE_PASS) ? Ip : stg[WA];

  logic [0:LEN-1] op_q, op_d;
  logic           vld_q, vld_d;

  always_comb begin
    op_d  = op_q;
    vld_d = in_valid;
    if (in_valid) op_d = res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      vld_q <= vld_d;
    end
  end

  assign Op        = op_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_comb_shifter.sv
// Directed and random checks of comb_shifter against hand-computed values and
// an index-formula reference model.
module tb_comb_shifter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [0:7] Ip;
  logic [2:0] amt;
  logic       dir;
  logic [1:0] mode;
  logic       in_valid;
  logic [0:7] Op;
  logic       out_valid;

  int n_pass  = 0;
  int n_total = 0;

  comb_shifter #(.LEN(8), .WA(3)) dut (
    .clk(clk), .rst_n(rst_n), .Ip(Ip), .amt(amt), .dir(dir), .mode(mode),
    .in_valid(in_valid), .Op(Op), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [0:7] ref_fn(logic [0:7] ip, int a, logic d, logic [1:0] m);
    logic [0:7] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (m == 2'b11)      r[i] = ip[i];
      else if (m == 2'b10) r[i] = d ? ip[(i - a + 8) % 8] : ip[(i + a) % 8];
      else if (!d)         r[i] = (i + a <= 7) ? ip[i + a] : 1'b0;
      else                 r[i] = (i >= a) ? ip[i - a] : ((m == 2'b01) ? ip[0] : 1'b0);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  task automatic drive(input logic [0:7] ip, input logic [2:0] a, input logic d,
                       input logic [1:0] m, input logic v);
    Ip = ip; amt = a; dir = d; mode = m; in_valid = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string tag, input logic [0:7] ip, input logic [2:0] a,
                        input logic d, input logic [1:0] m, input logic [0:7] exp);
    drive(ip, a, d, m, 1'b1);
    tick();
    chk({tag, "_op"}, Op, exp);
    chk({tag, "_vld"}, {7'b0, out_valid}, 8'h01);
  endtask

  logic [0:7] held;
  logic [0:7] exp_q;

  initial begin
    rst_n = 1'b0;
    drive(8'b1111_1111, 3'd1, 1'b0, 2'b11, 1'b1);
    tick();
    chk("rst_op0", Op, 8'h00);
    chk("rst_vld0", {7'b0, out_valid}, 8'h00);
    tick();
    chk("rst_op1", Op, 8'h00);
    chk("rst_vld1", {7'b0, out_valid}, 8'h00);

    rst_n = 1'b1;
    op_chk("lsl1",  8'b0000_0001, 3'd1, 1'b0, 2'b00, 8'b0000_0010);
    op_chk("asr3",  8'b1000_0000, 3'd3, 1'b1, 2'b01, 8'b1111_0000);
    op_chk("lsr3",  8'b1000_0000, 3'd3, 1'b1, 2'b00, 8'b0001_0000);
    op_chk("ror1",  8'b0000_0001, 3'd1, 1'b1, 2'b10, 8'b1000_0000);
    op_chk("rol7",  8'b0000_0100, 3'd7, 1'b0, 2'b10, 8'b0000_0010);
    op_chk("pass",  8'b1011_0110, 3'd5, 1'b0, 2'b11, 8'b1011_0110);
    op_chk("passr", 8'b1011_0110, 3'd6, 1'b1, 2'b11, 8'b1011_0110);
    op_chk("asr2p", 8'b0100_0000, 3'd2, 1'b1, 2'b01, 8'b0001_0000);
    op_chk("asl2",  8'b1100_0001, 3'd2, 1'b0, 2'b01, 8'b0000_0100);
    op_chk("lsl7",  8'b1000_0001, 3'd7, 1'b0, 2'b00, 8'b1000_0000);
    op_chk("lsr7",  8'b1000_0001, 3'd7, 1'b1, 2'b00, 8'b0000_0001);
    op_chk("asr7",  8'b1000_0001, 3'd7, 1'b1, 2'b01, 8'b1111_1111);
    op_chk("ror3",  8'b1011_0110, 3'd3, 1'b1, 2'b10, 8'b1101_0110);
    op_chk("a0log", 8'b1011_0110, 3'd0, 1'b1, 2'b00, 8'b1011_0110);
    op_chk("a0ari", 8'b1011_0110, 3'd0, 1'b1, 2'b01, 8'b1011_0110);
    op_chk("a0rot", 8'b1011_0110, 3'd0, 1'b0, 2'b10, 8'b1011_0110);
    held = 8'b1011_0110;

    for (int i = 0; i < 3; i++) begin
      drive(8'(8'h5A + i), 3'(i + 1), 1'b0, 2'b00, 1'b0);
      tick();
      chk("hold_op", Op, held);
      chk("hold_vld", {7'b0, out_valid}, 8'h00);
    end

    rst_n = 1'b0;
    drive(8'b1111_0000, 3'd1, 1'b0, 2'b00, 1'b1);
    tick();
    chk("rst2_op", Op, 8'h00);
    chk("rst2_vld", {7'b0, out_valid}, 8'h00);

    rst_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      drive(8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom), 2'($urandom), 1'b1);
      exp_q = ref_fn(Ip, int'(amt), dir, mode);
      tick();
      chk("rand_op", Op, exp_q);
    end
    chk("rand_vld", {7'b0, out_valid}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/comb_shifter.md
COMB_SHIFTER -- requirements
Module: comb_shifter

Interface
REQ-001 The module SHALL be named comb_shifter, with one clock, clk, and a synchronous, active-low reset, rst_n.
REQ-002 Parameter LEN, default 8: data width in bits; legal values are powers of two, at least 2.
REQ-003 Parameter WA, default 3: shift-amount width; SHALL equal log2(LEN).
REQ-004 clk  input  1  rising-edge clock; all state updates on this edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 Ip  input  [0:LEN-1]  data in; index 0 is the MSB and the leftmost bit.
REQ-007 amt  input  [WA-1:0]  shift/rotate distance, 0..LEN-1.
REQ-008 dir  input  1  0 = left (toward index 0), 1 = right (toward index LEN-1).
REQ-009 mode  input  [1:0]  00 logical, 01 arithmetic, 10 rotate, 11 pass-through.
REQ-010 in_valid  input  1  when high, capture the operation this cycle.
REQ-011 Op  output  [0:LEN-1]  registered result; index 0 is the MSB.
REQ-012 out_valid  output  1  high for the one cycle in which Op holds a result captured on the previous edge.

Function
REQ-013 Result computation SHALL be purely combinational from Ip, amt, dir and mode, as a log2(LEN)-stage barrel network, with no loops or latches.
REQ-014 Logical left: result[i] = Ip[i+amt] for i+amt <= LEN-1; all other bits are 0.
REQ-015 Logical right: result[i] = Ip[i-amt] for i >= amt; all other bits are 0.
REQ-016 Arithmetic left SHALL equal logical left.
REQ-017 Arithmetic right SHALL be the same as logical right, except that vacated bits are filled with Ip[0].
REQ-018 Rotate left: result[i] = Ip[(i+amt) mod LEN].
REQ-019 Rotate right: result[i] = Ip[(i-amt) mod LEN].
REQ-020 Pass-through (mode 11): result = Ip, regardless of amt and dir.
REQ-021 amt = 0 SHALL yield result = Ip in every mode.
REQ-022 Latency: on a rising edge with rst_n=1 and in_valid=1, Op SHALL load the result and out_valid SHALL go to 1 for the next cycle (1-cycle latency).
REQ-023 On a rising edge with rst_n=1 and in_valid=0, Op SHALL hold its value and out_valid SHALL go to 0.
REQ-024 Back-to-back in_valid SHALL produce one result per cycle, with no bubbles.
REQ-025 Changes to the inputs between clock edges SHALL NOT affect Op.
REQ-026 No handshake or backpressure exists; the block is always ready.

Reset
REQ-027 On a rising edge with rst_n=0: Op SHALL become all zeros and out_valid SHALL become 0.
REQ-028 Reset SHALL take priority over in_valid; an operation presented in the same cycle is discarded.
REQ-029 Op and out_valid SHALL remain 0 for as long as rst_n is low.
REQ-030 The first operation SHALL be accepted on the first edge at which rst_n=1.

Verification
REQ-031 Reset, then Ip=0000_0001, amt=1, dir=0, mode=00, in_valid=1 for one edge -> Op=0000_0010 and out_valid=1 on the next cycle.
REQ-032 Ip=1000_0000, amt=3, dir=1, mode=01 -> Op=1111_0000.
REQ-033 Ip=1000_0000, amt=3, dir=1, mode=00 -> Op=0001_0000.
REQ-034 Ip=0000_0001, amt=1, dir=1, mode=10 -> Op=1000_0000.
REQ-035 Ip=0000_0100, amt=7, dir=0, mode=10 -> Op=0000_0010.
REQ-036 Ip=1011_0110, amt=5, mode=11 -> Op=1011_0110.
REQ-037 Hold-then-reset sequence:
- in_valid=0 for 3 edges after a result -> Op unchanged and out_valid=0.
- rst_n=0 asserted together with in_valid=1 -> Op=0000_0000 and out_valid=0.
REQ-038 Randomized check: 1000 random Ip/amt/dir/mode vectors, each compared against a reference model one cycle later.
